// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MIPS32 run controller: FSM state encoding and
// instruction-field constants/encoders used to build test programs.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RESET_HOLD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } run_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; the controller reuses one instance
// for both the core-reset hold and the pipeline drain countdowns.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign a default first so no path leaves a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Program loader and run sequencer for the five-stage MIPS32 core: streams a
// program into instruction memory, releases the core and watches the fetch PC.
module pipeline_run_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 5,
    parameter int MAX_CYCLES   = 1024,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    input  logic [31:0]       core_pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   prog_len
);

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_CYCLES);

    run_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ld_ready_q, ld_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              xfer;
    logic [31:0]       end_pc;

    cycle_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign xfer   = ld_valid && ld_ready_q;
    // First byte address past the loaded program.
    assign end_pc = 32'({prog_len_q, 2'b00});

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        timeout_d    = timeout_q;
        count_d      = count_q;
        prog_len_d   = prog_len_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    ptr_d     = '0;
                    timeout_d = 1'b0;
                    count_d   = '0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr_q;
                    imem_wdata_d = ld_data;
                    ptr_d        = ptr_q + 1'b1;
                    // Leave on the marked last word or when memory is full.
                    if (ld_last || (ptr_q == '1)) begin
                        prog_len_d = {1'b0, ptr_q} + 1'b1;
                        state_d    = ST_RESET_HOLD;
                        tmr_load   = 1'b1;
                        tmr_val    = HOLD_LOAD;
                    end
                end
            end
            ST_RESET_HOLD: begin
                if (tmr_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                count_d = count_q + 1'b1;
                if (core_pc >= end_pc) begin
                    state_d  = ST_DRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LOAD;
                end else if (count_d >= MAX_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DRAIN: begin
                count_d = count_q + 1'b1;
                if (tmr_zero) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered status flags are derived from the state being entered.
        ld_ready_d = (state_d == ST_LOAD);
        core_rst_d = !((state_d == ST_RUN) || (state_d == ST_DRAIN));
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_RESET_HOLD) ||
                     (state_d == ST_RUN)  || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            ld_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            prog_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ld_ready_q   <= ld_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
            prog_len_q   <= prog_len_d;
        end
    end

    assign ld_ready    = ld_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;
    assign prog_len    = prog_len_q;

endmodule
